// File: rtl/wb_burst_master_if.sv
// Wishbone B3 master-side bus bundle used between the burst master and its slave port.
interface wb_burst_master_if;
  logic [31:0] wbm_adr_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
    output wbm_we_o, wbm_sel_o, wbm_dat_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i
  );

  modport slave (
    input  wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_we_o, wbm_sel_o, wbm_dat_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone B3 burst initiator: one command becomes a linear incrementing
// burst, with write data from a valid/ready stream and read data returned on another.
module wb_burst_master #(
  parameter int LEN_W     = 5,
  parameter int MAX_RETRY = 3
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_sel,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done_o,
  output logic             done_err_o,
  wb_burst_master_if.master wbm
);

  localparam int REM_W = LEN_W + 1;
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             single_q, single_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             cyc_q, cyc_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             done_q, done_d;
  logic             done_err_q, done_err_d;

  logic             stb;
  logic             beat_ok;
  logic [RTY_W-1:0] retry_inc;

  // The master throttles itself through stb: no source word / no sink room means a wait state.
  assign stb       = cyc_q & (we_q ? wr_valid : rd_ready);
  assign beat_ok   = stb & wbm.wbm_ack_i & ~wbm.wbm_err_i & ~wbm.wbm_rty_i;
  assign retry_inc = retry_q + RTY_W'(1);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    single_d   = single_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d     = cmd_we;
          adr_d    = cmd_adr & 32'hFFFF_FFFC;
          rem_d    = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
          single_d = (cmd_len == LEN_W'(1));
          retry_d  = '0;
          state_d  = S_BUS;
        end
      end
      S_BUS: begin
        if (stb) begin
          if (wbm.wbm_err_i) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else if (wbm.wbm_rty_i) begin
            retry_d = retry_inc;
            if (retry_inc == RTY_W'(MAX_RETRY)) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              done_err_d = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else if (wbm.wbm_ack_i) begin
            adr_d = adr_q + 32'd4;
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_GAP:   state_d = S_BUS;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cyc_d       = (state_d == S_BUS);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      rem_q       <= '0;
      single_q    <= 1'b0;
      retry_q     <= '0;
      cyc_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      rem_q       <= rem_d;
      single_q    <= single_d;
      retry_q     <= retry_d;
      cyc_q       <= cyc_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign done_o     = done_q;
  assign done_err_o = done_err_q;

  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_bte_o = 2'b00;
  assign wbm.wbm_cti_o = !cyc_q              ? 3'b000 :
                         single_q            ? 3'b000 :
                         (rem_q == REM_W'(1)) ? 3'b111 : 3'b010;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = we_q ? wr_sel : 4'hF;
  assign wbm.wbm_dat_o = wr_data;

  // Read data is a zero-latency pass-through of the slave's data on the accepted beat.
  assign wr_ready = beat_ok & we_q;
  assign rd_valid = beat_ok & ~we_q;
  assign rd_data  = wbm.wbm_dat_i;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: a cycle-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized commands and slave behaviour.
module tb_wb_burst_master;
  localparam int LEN_W     = 5;
  localparam int MAX_RETRY = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wr_data;
  logic [3:0]       wr_sel;
  logic             wr_valid, wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid, rd_ready;
  logic             done_o, done_err_o;

  wb_burst_master_if wb();

  wb_burst_master #(.LEN_W(LEN_W), .MAX_RETRY(MAX_RETRY)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_sel(wr_sel), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_o(done_o), .done_err_o(done_err_o),
    .wbm(wb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want completion", nm);
  endtask

  // Behavioural model: what the command is doing this cycle, in beats/addresses/retries.
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0, m_on_bus = 1'b0, m_pause = 1'b0;
  bit          m_finish = 1'b0, m_ferr = 1'b0, m_we = 1'b0, m_len1 = 1'b0;
  logic [31:0] m_adr = '0;
  int          m_left = 0, m_retries = 0;
  int          cyc_n = 0;

  // Stimulus policy and scripts (vq: stream-valid per bus cycle, rq: response per strobe).
  int p_valid = 100, p_ack = 100, p_rty = 0, p_err = 0;
  bit fix_w = 1'b0;
  logic [31:0] fix_data = '0;
  logic [3:0]  fix_sel = '0;
  int vq[$];
  int rq[$];

  // Per-command observation log used by the directed scenarios.
  logic [31:0] log_adr[$];
  logic [2:0]  log_cti[$];
  int cyc_cnt, stb_cnt, rdv_cnt, wrr_cnt, done_cnt, gap_cnt, done_cyc, last_ack_cyc;
  logic        done_err_v;
  logic [31:0] done_adr, l_dat;
  logic [3:0]  l_sel;
  logic        l_we;
  logic [2:0]  l_cti;

  task automatic clear_logs();
    log_adr.delete();
    log_cti.delete();
    cyc_cnt = 0; stb_cnt = 0; rdv_cnt = 0; wrr_cnt = 0; done_cnt = 0; gap_cnt = 0;
    done_cyc = 0; last_ack_cyc = -100; done_err_v = 1'b0; done_adr = '0;
    l_dat = '0; l_sel = '0; l_we = 1'b0; l_cti = '0;
  endtask

  always @(negedge clk) begin
    bit e_idle, e_stb, e_beat;
    logic [2:0] e_cti;
    cyc_n++;
    e_idle = !m_active && !m_finish;
    e_stb  = m_on_bus && (m_we ? wr_valid : rd_ready);
    e_beat = e_stb && wb.wbm_ack_i && !wb.wbm_err_i && !wb.wbm_rty_i;
    e_cti  = m_len1 ? 3'b000 : ((m_left == 1) ? 3'b111 : 3'b010);
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, e_idle);
      chk("cyc", wb.wbm_cyc_o, m_on_bus);
      chk("stb", wb.wbm_stb_o, e_stb);
      chk("done", done_o, m_finish);
      if (m_finish) chk("done_err", done_err_o, m_ferr);
      chk("bte", wb.wbm_bte_o, 2'b00);
      chk("wr_ready", wr_ready, e_beat && m_we);
      chk("rd_valid", rd_valid, e_beat && !m_we);
      if (m_on_bus) begin
        chk("adr", wb.wbm_adr_o, m_adr);
        chk("cti", wb.wbm_cti_o, e_cti);
        chk("we", wb.wbm_we_o, m_we);
        chk("sel", wb.wbm_sel_o, m_we ? wr_sel : 4'hF);
        if (m_we) chk("dat_o", wb.wbm_dat_o, wr_data);
      end
      if (e_beat && !m_we) chk("rd_data", rd_data, wb.wbm_dat_i);
    end

    if (wb.wbm_cyc_o) begin
      cyc_cnt++;
      log_adr.push_back(wb.wbm_adr_o);
      log_cti.push_back(wb.wbm_cti_o);
    end else if (cyc_cnt > 0 && !done_o && done_cnt == 0) begin
      gap_cnt++;
    end
    if (wb.wbm_stb_o) begin
      stb_cnt++;
      l_dat = wb.wbm_dat_o; l_sel = wb.wbm_sel_o; l_we = wb.wbm_we_o; l_cti = wb.wbm_cti_o;
      if (wb.wbm_ack_i && !wb.wbm_err_i && !wb.wbm_rty_i) last_ack_cyc = cyc_n;
    end
    if (rd_valid) rdv_cnt++;
    if (wr_ready) wrr_cnt++;
    if (done_o) begin
      done_cnt++;
      done_err_v = done_err_o;
      done_cyc   = cyc_n;
      done_adr   = wb.wbm_adr_o;
    end

    // Advance the model to the next cycle.
    if (!rst_n) begin
      m_active = 0; m_on_bus = 0; m_pause = 0; m_finish = 0; m_ferr = 0;
      m_we = 0; m_len1 = 0; m_adr = '0; m_left = 0; m_retries = 0;
    end else if (m_finish) begin
      m_finish = 0;
      m_ferr   = 0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_active  = 1; m_on_bus = 1;
        m_we      = cmd_we;
        m_adr     = {cmd_adr[31:2], 2'b00};
        m_left    = (cmd_len == 0) ? (1 << LEN_W) : int'(cmd_len);
        m_len1    = (m_left == 1);
        m_retries = 0;
      end
    end else if (m_pause) begin
      m_pause = 0; m_on_bus = 1;
    end else if (e_stb) begin
      if (wb.wbm_err_i) begin
        m_active = 0; m_on_bus = 0; m_finish = 1; m_ferr = 1;
      end else if (wb.wbm_rty_i) begin
        m_retries++;
        m_on_bus = 0;
        if (m_retries >= MAX_RETRY) begin
          m_active = 0; m_finish = 1; m_ferr = 1;
        end else begin
          m_pause = 1;
        end
      end else if (wb.wbm_ack_i) begin
        m_adr = m_adr + 32'd4;
        m_left--;
        if (m_left == 0) begin
          m_active = 0; m_on_bus = 0; m_finish = 1; m_ferr = 0;
        end
      end
    end
  end

  task automatic drive();
    bit v;
    int r, code;
    v = 1'b0;
    wr_valid = 1'($urandom_range(1));
    rd_ready = 1'($urandom_range(1));
    if (m_on_bus) begin
      if (vq.size() > 0) v = (vq.pop_front() != 0);
      else               v = ($urandom_range(99) < p_valid);
      if (m_we) wr_valid = v; else rd_ready = v;
    end
    wr_data = fix_w ? fix_data : $urandom();
    wr_sel  = fix_w ? fix_sel : 4'($urandom());
    wb.wbm_dat_i = $urandom();
    cmd_valid = (!m_active && !m_finish) ? 1'b0 : 1'($urandom_range(1));
    cmd_we  = 1'($urandom_range(1));
    cmd_adr = $urandom();
    cmd_len = LEN_W'($urandom());
    wb.wbm_ack_i = 1'b0; wb.wbm_err_i = 1'b0; wb.wbm_rty_i = 1'b0;
    if (m_on_bus && v) begin
      if (rq.size() > 0) begin
        code = rq.pop_front();
      end else begin
        r = $urandom_range(99);
        if (r < p_err)                      code = 2;
        else if (r < p_err + p_rty)         code = 1;
        else if (r < p_err + p_rty + p_ack) code = 0;
        else                                code = 4;
        if (code == 1) wb.wbm_ack_i = 1'($urandom_range(1));
        if (code == 2) begin
          wb.wbm_ack_i = 1'($urandom_range(1));
          wb.wbm_rty_i = 1'($urandom_range(1));
        end
      end
      case (code)
        0: wb.wbm_ack_i = 1'b1;
        1: wb.wbm_rty_i = 1'b1;
        2: wb.wbm_err_i = 1'b1;
        3: begin wb.wbm_ack_i = 1'b1; wb.wbm_err_i = 1'b1; end
        default: ;
      endcase
    end else begin
      {wb.wbm_ack_i, wb.wbm_err_i, wb.wbm_rty_i} = 3'($urandom());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic issue(input bit we, input logic [31:0] adr, input logic [LEN_W-1:0] len);
    int n = 0;
    while ((m_active || m_finish) && n < 4000) begin
      tick();
      n++;
    end
    if (m_active || m_finish) timeout("wait_idle");
    clear_logs();
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
  endtask

  task automatic run_cmd(input bit we, input logic [31:0] adr, input logic [LEN_W-1:0] len,
                         input int budget);
    int n = 0;
    issue(we, adr, len);
    do begin
      tick();
      n++;
    end while (done_cnt == 0 && n < budget);
    if (done_cnt == 0) timeout("wait_done");
  endtask

  function automatic logic [31:0] adr_at(input int i);
    return (i < log_adr.size()) ? log_adr[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [2:0] cti_at(input int i);
    return (i < log_cti.size()) ? log_cti[i] : 3'bxxx;
  endfunction

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_len = '0;
    wr_data = '0; wr_sel = '0; wr_valid = 0; rd_ready = 0;
    wb.wbm_ack_i = 0; wb.wbm_err_i = 0; wb.wbm_rty_i = 0; wb.wbm_dat_i = '0;
    clear_logs();
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_cyc", wb.wbm_cyc_o, 1'b0);
    chk("rst_stb", wb.wbm_stb_o, 1'b0);
    chk("rst_we", wb.wbm_we_o, 1'b0);
    chk("rst_adr", wb.wbm_adr_o, 32'h0);
    chk("rst_cti", wb.wbm_cti_o, 3'b000);
    chk("rst_done", done_o, 1'b0);
    chk("rst_done_err", done_err_o, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Read burst of 4 at 0x100, slave acks every strobe.
    run_cmd(1'b0, 32'h100, 5'd4, 100);
    chk("rd4_cyc_cycles", cyc_cnt, 4);
    for (int i = 0; i < 4; i++) chk("rd4_adr", adr_at(i), 32'h100 + 32'(4 * i));
    chk("rd4_cti0", cti_at(0), 3'b010);
    chk("rd4_cti2", cti_at(2), 3'b010);
    chk("rd4_cti3", cti_at(3), 3'b111);
    chk("rd4_rdv", rdv_cnt, 4);
    chk("rd4_err", done_err_v, 1'b0);
    chk("rd4_done_lat", done_cyc - last_ack_cyc, 1);

    // Single-beat write with fixed data.
    fix_w = 1'b1; fix_data = 32'hDEADBEEF; fix_sel = 4'h3;
    run_cmd(1'b1, 32'h40, 5'd1, 100);
    fix_w = 1'b0;
    chk("wr1_stb", stb_cnt, 1);
    chk("wr1_cyc", cyc_cnt, 1);
    chk("wr1_dat", l_dat, 32'hDEADBEEF);
    chk("wr1_sel", l_sel, 4'h3);
    chk("wr1_we", l_we, 1'b1);
    chk("wr1_cti", l_cti, 3'b000);
    chk("wr1_wrr", wrr_cnt, 1);

    // Write of 3 with the source stalling for two cycles after beat 1.
    vq.push_back(1); vq.push_back(0); vq.push_back(0); vq.push_back(1); vq.push_back(1);
    run_cmd(1'b1, 32'h300, 5'd3, 100);
    chk("wr3_cyc", cyc_cnt, 5);
    chk("wr3_stb", stb_cnt, 3);
    chk("wr3_wrr", wrr_cnt, 3);
    chk("wr3_adr1", adr_at(1), 32'h304);
    chk("wr3_adr3", adr_at(3), 32'h304);
    chk("wr3_adr4", adr_at(4), 32'h308);

    // One retry on beat 2, then the burst completes.
    rq.push_back(0); rq.push_back(1);
    run_cmd(1'b0, 32'h200, 5'd4, 100);
    chk("rty1_adr2", adr_at(2), 32'h204);
    chk("rty1_cti2", cti_at(2), 3'b010);
    chk("rty1_adr4", adr_at(4), 32'h20C);
    chk("rty1_cti4", cti_at(4), 3'b111);
    chk("rty1_gap", gap_cnt, 1);
    chk("rty1_rdv", rdv_cnt, 4);
    chk("rty1_err", done_err_v, 1'b0);

    // Three retries on beat 2 abort the command.
    rq.push_back(0); rq.push_back(1); rq.push_back(1); rq.push_back(1);
    run_cmd(1'b0, 32'h200, 5'd4, 100);
    chk("rty3_cyc", cyc_cnt, 4);
    chk("rty3_adr3", adr_at(3), 32'h204);
    chk("rty3_gap", gap_cnt, 2);
    chk("rty3_rdv", rdv_cnt, 1);
    chk("rty3_err", done_err_v, 1'b1);

    // ack together with err on the first beat.
    rq.push_back(3);
    run_cmd(1'b0, 32'h400, 5'd8, 100);
    chk("err_rdv", rdv_cnt, 0);
    chk("err_flag", done_err_v, 1'b1);
    chk("err_cyc", cyc_cnt, 1);
    chk("err_adr", done_adr, 32'h400);

    // Length 0 means 32 beats.
    run_cmd(1'b0, 32'h1000, 5'd0, 200);
    chk("len0_rdv", rdv_cnt, 32);
    chk("len0_cyc", cyc_cnt, 32);
    chk("len0_adr31", adr_at(31), 32'h107C);
    chk("len0_cti30", cti_at(30), 3'b010);
    chk("len0_cti31", cti_at(31), 3'b111);

    // Address wraps past the top; low address bits are dropped.
    run_cmd(1'b1, 32'hFFFF_FFFF, 5'd2, 100);
    chk("wrap_adr0", adr_at(0), 32'hFFFF_FFFC);
    chk("wrap_adr1", adr_at(1), 32'h0000_0000);
    chk("wrap_wrr", wrr_cnt, 2);

    // Reset in the middle of a stalled burst.
    p_ack = 0;
    issue(1'b0, 32'h500, 5'd8);
    tick(); tick(); tick();
    chk("mid_cyc_before", wb.wbm_cyc_o, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_cyc_after", wb.wbm_cyc_o, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_no_done", done_cnt, 0);
    p_ack = 100;

    // Randomized commands, stream throttling and slave responses.
    for (int k = 0; k < 200; k++) begin
      p_valid = ($urandom_range(2) == 0) ? 100 : 30 + $urandom_range(60);
      p_err   = $urandom_range(4);
      p_rty   = $urandom_range(12);
      p_ack   = 100 - p_err - p_rty - $urandom_range(20);
      a = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom();
      run_cmd(1'($urandom_range(1)), a,
              ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(1, 8)), 3000);
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
